// File: rtl/formacao_inimigos.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : formacao_inimigos
// Description : Enemy-formation engine. Holds a ROWS x COLS grid of enemies,
//               marches it side to side and downward on a frame clock, scans
//               the grid one enemy per cycle for player-bullet hits, keeps
//               the score, and flags end of wave or invasion.
//               Optional enemy shots are compiled in with FORMACAO_TIRO_EN.
// Ports       : CLOCK_50, reset, reiniciarJogo (restart = reset), pausa
//               largura_inimigo / altura_inimigo : enemy box size
//               bala_x / bala_y / bala_ativa     : player bullet
//               tiro_consumido                   : clear enemy shot
//               x_inimigo / y_inimigo            : 10 bits per enemy
//               vivos, acerto, acerto_idx, pontos, todos_mortos, invadiu
//               tiro_x / tiro_y / tiro_ativo     : enemy shot
// Macro       : FORMACAO_TIRO_EN enables the enemy shot and its LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module formacao_inimigos #(
    parameter int ROWS           = 2,
    parameter int COLS           = 5,
    parameter int FRAME_DIV      = 833333,
    parameter int MOVE_FRAMES    = 8,
    parameter int STEP           = 4,
    parameter int DROP           = 8,
    parameter int GAP            = 4,
    parameter int X_INI          = 10,
    parameter int Y_INI          = 40,
    parameter int X_MAX          = 630,
    parameter int Y_INVASAO      = 420,
    parameter int PONTOS_INIMIGO = 10,
    parameter int TIRO_VEL       = 3
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      reiniciarJogo,
    input  logic                      pausa,
    input  logic [9:0]                largura_inimigo,
    input  logic [9:0]                altura_inimigo,
    input  logic [9:0]                bala_x,
    input  logic [9:0]                bala_y,
    input  logic                      bala_ativa,
    input  logic                      tiro_consumido,
    output logic [10*ROWS*COLS-1:0]   x_inimigo,
    output logic [10*ROWS*COLS-1:0]   y_inimigo,
    output logic [ROWS*COLS-1:0]      vivos,
    output logic                      acerto,
    output logic [5:0]                acerto_idx,
    output logic [15:0]               pontos,
    output logic                      todos_mortos,
    output logic                      invadiu,
    output logic [9:0]                tiro_x,
    output logic [9:0]                tiro_y,
    output logic                      tiro_ativo
);

    localparam int c_N    = ROWS * COLS;
    localparam int c_FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int c_MC_W = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

    localparam logic [1:0] c_DIREITA  = 2'd0;
    localparam logic [1:0] c_ESQUERDA = 2'd1;
    localparam logic [1:0] c_FIM      = 2'd2;

    // Restart behaves exactly like reset.
    logic w_rst;
    assign w_rst = reset | reiniciarJogo;

    // ------------------------------------------------------------------------
    // Geometry (11-bit arithmetic throughout)
    // ------------------------------------------------------------------------
    logic [10:0] w_larg, w_alt, w_pitch_x, w_pitch_y, w_width, w_height;
    assign w_larg    = {1'b0, largura_inimigo};
    assign w_alt     = {1'b0, altura_inimigo};
    assign w_pitch_x = w_larg + 11'(GAP);
    assign w_pitch_y = w_alt + 11'(GAP);
    assign w_width   = 11'(COLS) * w_pitch_x - 11'(GAP);
    assign w_height  = 11'(ROWS) * w_pitch_y - 11'(GAP);

    logic [10:0] r_x_form, r_y_form;
    logic [1:0]  r_state;

    // ------------------------------------------------------------------------
    // Frame and march timing
    // ------------------------------------------------------------------------
    logic [c_FC_W-1:0] r_fc;
    logic [c_MC_W-1:0] r_mc;
    logic              w_tick, w_step;

    assign w_tick = !pausa && (r_fc == c_FC_W'(FRAME_DIV - 1));
    assign w_step = w_tick && (r_mc == c_MC_W'(MOVE_FRAMES - 1));

    always_ff @(posedge CLOCK_50) begin
        if (w_rst) begin
            r_fc <= '0;
            r_mc <= '0;
        end else if (!pausa) begin
            if (w_tick) begin
                r_fc <= '0;
                if (w_step) r_mc <= '0;
                else        r_mc <= r_mc + 1'b1;
            end else begin
                r_fc <= r_fc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Hit scanner: one enemy per cycle, row/col tracked alongside the index
    // so no divider is needed.
    // ------------------------------------------------------------------------
    logic [5:0]      r_idx, r_col, r_row;
    logic            r_armado;
    logic [c_N-1:0]  r_vivos;
    logic            r_acerto;
    logic [5:0]      r_acerto_idx;
    logic [15:0]     r_pontos;

    logic [63:0]     w_vivos64;
    logic [10:0]     w_sx, w_sy, w_bx, w_by;
    logic            w_hit;
    logic [16:0]     w_pontos_sum;

    assign w_vivos64 = 64'(r_vivos);
    assign w_sx      = r_x_form + 11'(r_col) * w_pitch_x;
    assign w_sy      = r_y_form + 11'(r_row) * w_pitch_y;
    assign w_bx      = {1'b0, bala_x};
    assign w_by      = {1'b0, bala_y};

    // Judged on the current (pre-move) coordinates.
    assign w_hit = !pausa && (r_state != c_FIM) && r_armado && bala_ativa &&
                   w_vivos64[r_idx] &&
                   (w_bx >= w_sx) && (w_bx < w_sx + w_larg) &&
                   (w_by >= w_sy) && (w_by < w_sy + w_alt);

    assign w_pontos_sum = {1'b0, r_pontos} + 17'(PONTOS_INIMIGO);

    always_ff @(posedge CLOCK_50) begin
        if (w_rst) begin
            r_idx        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_armado     <= 1'b0;
            r_vivos      <= {c_N{1'b1}};
            r_acerto     <= 1'b0;
            r_acerto_idx <= '0;
            r_pontos     <= '0;
        end else begin
            r_acerto <= 1'b0;
            if (!pausa) begin
                if (r_idx == 6'(c_N - 1)) begin
                    r_idx <= '0;
                    r_col <= '0;
                    r_row <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    if (r_col == 6'(COLS - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end

                if (w_hit) begin
                    r_vivos      <= r_vivos & ~(c_N'(1) << r_idx);
                    r_acerto     <= 1'b1;
                    r_acerto_idx <= r_idx;
                    r_pontos     <= w_pontos_sum[16] ? 16'hFFFF : w_pontos_sum[15:0];
                    // One kill per bullet: re-arm only once the bullet is gone.
                    r_armado     <= 1'b0;
                end else if (!bala_ativa) begin
                    r_armado <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // March FSM and end-of-game flags
    // ------------------------------------------------------------------------
    logic r_todos_mortos, r_invadiu;
    logic w_mortos, w_invade;

    assign w_mortos = (r_vivos == '0);
    assign w_invade = (r_y_form + w_height) >= 11'(Y_INVASAO);

    always_ff @(posedge CLOCK_50) begin
        if (w_rst) begin
            r_state        <= c_DIREITA;
            r_x_form       <= 11'(X_INI);
            r_y_form       <= 11'(Y_INI);
            r_todos_mortos <= 1'b0;
            r_invadiu      <= 1'b0;
        end else if (!pausa) begin
            case (r_state)
                c_DIREITA, c_ESQUERDA: begin
                    if (w_mortos || w_invade) begin
                        r_state        <= c_FIM;
                        r_todos_mortos <= w_mortos;
                        r_invadiu      <= w_invade;
                    end else if (w_step) begin
                        if (r_state == c_DIREITA) begin
                            if (r_x_form + w_width + 11'(STEP) > 11'(X_MAX)) begin
                                r_y_form <= r_y_form + 11'(DROP);
                                r_state  <= c_ESQUERDA;
                            end else begin
                                r_x_form <= r_x_form + 11'(STEP);
                            end
                        end else begin
                            if (r_x_form < 11'(STEP)) begin
                                r_y_form <= r_y_form + 11'(DROP);
                                r_state  <= c_DIREITA;
                            end else begin
                                r_x_form <= r_x_form - 11'(STEP);
                            end
                        end
                    end
                end
                default: ;  // c_FIM: only reset/restart leaves
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Per-enemy positions, truncated to 10 bits
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < c_N; gi++) begin : g_enemy
            localparam int c_R = gi / COLS;
            localparam int c_C = gi % COLS;
            assign x_inimigo[10*gi +: 10] = 10'(r_x_form + 11'(c_C) * w_pitch_x);
            assign y_inimigo[10*gi +: 10] = 10'(r_y_form + 11'(c_R) * w_pitch_y);
        end
    endgenerate

    assign vivos        = r_vivos;
    assign acerto       = r_acerto;
    assign acerto_idx   = r_acerto_idx;
    assign pontos       = r_pontos;
    assign todos_mortos = r_todos_mortos;
    assign invadiu      = r_invadiu;

    // ------------------------------------------------------------------------
    // Enemy shot
    // ------------------------------------------------------------------------
`ifdef FORMACAO_TIRO_EN
    logic [7:0]   r_lfsr;
    logic [9:0]   r_tiro_x, r_tiro_y;
    logic         r_tiro_ativo;
    logic [7:0]   w_col_sel;
    logic [255:0] w_vivos256;
    logic         w_col_has;
    logic [7:0]   w_low_row;

    assign w_col_sel  = r_lfsr % 8'(COLS);
    assign w_vivos256 = 256'(r_vivos);

    // Lowest (highest row number) living enemy of the selected column.
    always_comb begin
        w_col_has = 1'b0;
        w_low_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (w_vivos256[8'(r * COLS) + w_col_sel]) begin
                w_col_has = 1'b1;
                w_low_row = 8'(r);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_rst) begin
            r_lfsr       <= 8'hA5;
            r_tiro_x     <= '0;
            r_tiro_y     <= '0;
            r_tiro_ativo <= 1'b0;
        end else if (!pausa) begin
            if (w_tick)
                r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

            // Consume has priority over spawning in the same cycle.
            if (r_state == c_FIM || tiro_consumido) begin
                r_tiro_ativo <= 1'b0;
            end else if (r_tiro_ativo) begin
                if (r_tiro_y >= 10'd470)
                    r_tiro_ativo <= 1'b0;
                else if (w_tick)
                    r_tiro_y <= r_tiro_y + 10'(TIRO_VEL);
            end else if (w_step && w_col_has) begin
                r_tiro_ativo <= 1'b1;
                r_tiro_x     <= 10'(r_x_form + 11'(w_col_sel) * w_pitch_x +
                                    {2'b00, largura_inimigo[9:1]});
                r_tiro_y     <= 10'(r_y_form + 11'(w_low_row) * w_pitch_y + w_alt);
            end
        end
    end

    assign tiro_x     = r_tiro_x;
    assign tiro_y     = r_tiro_y;
    assign tiro_ativo = r_tiro_ativo;
`else
    logic w_unused;
    assign w_unused   = tiro_consumido;
    assign tiro_x     = '0;
    assign tiro_y     = '0;
    assign tiro_ativo = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_formacao_inimigos.sv
`timescale 1ns/1ps
`default_nettype none
module tb_formacao_inimigos;

    logic        clk = 1'b0;
    logic        reset = 1'b1, reiniciarJogo = 1'b0, pausa = 1'b0;
    logic [9:0]  largura_inimigo = 10'd16, altura_inimigo = 10'd8;
    logic [9:0]  bala_x = '0, bala_y = '0;
    logic        bala_ativa = 1'b0, tiro_consumido = 1'b0;
    logic [59:0] x_inimigo, y_inimigo;
    logic [5:0]  vivos;
    logic        acerto;
    logic [5:0]  acerto_idx;
    logic [15:0] pontos;
    logic        todos_mortos, invadiu;
    logic [9:0]  tiro_x, tiro_y;
    logic        tiro_ativo;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hit_cyc = 0;

    always #5 clk = ~clk;

    formacao_inimigos #(
        .ROWS(2), .COLS(3), .FRAME_DIV(4), .MOVE_FRAMES(2), .STEP(4), .DROP(8),
        .GAP(4), .X_INI(10), .Y_INI(20), .X_MAX(100)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .reiniciarJogo(reiniciarJogo), .pausa(pausa),
        .largura_inimigo(largura_inimigo), .altura_inimigo(altura_inimigo),
        .bala_x(bala_x), .bala_y(bala_y), .bala_ativa(bala_ativa),
        .tiro_consumido(tiro_consumido),
        .x_inimigo(x_inimigo), .y_inimigo(y_inimigo), .vivos(vivos),
        .acerto(acerto), .acerto_idx(acerto_idx), .pontos(pontos),
        .todos_mortos(todos_mortos), .invadiu(invadiu),
        .tiro_x(tiro_x), .tiro_y(tiro_y), .tiro_ativo(tiro_ativo)
    );

`ifdef FORMACAO_TIRO_EN
    // Reference frame timing and LFSR (x^8+x^6+x^5+x^4+1).
    logic [7:0] m_lfsr;
    int         m_fc, m_mc;
    always @(posedge clk) begin
        if (reset || reiniciarJogo) begin
            m_fc <= 0; m_mc <= 0; m_lfsr <= 8'hA5;
        end else if (!pausa) begin
            if (m_fc == 3) begin
                m_fc   <= 0;
                m_mc   <= (m_mc == 1) ? 0 : 1;
                m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            end else begin
                m_fc <= m_fc + 1;
            end
        end
    end
`endif

    function automatic logic [9:0] ex(input int i);
        return x_inimigo[10*i +: 10];
    endfunction
    function automatic logic [9:0] ey(input int i);
        return y_inimigo[10*i +: 10];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Pulse reset or restart for one edge; returns at the negedge right after release.
    task automatic do_reset(input bit restart);
        @(negedge clk);
        if (restart) reiniciarJogo = 1'b1; else reset = 1'b1;
        @(negedge clk);
        reiniciarJogo = 1'b0;
        reset = 1'b0;
        cyc = 0;
    endtask

    // Arm, then chase enemy i with the bullet until it is hit (bounded).
    task automatic kill(input int i);
        bit seen;
        bala_ativa = 1'b0;
        step(1);
        bala_ativa = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            bala_x = 10'(ex(i) + 10'd8);
            bala_y = 10'(ey(i) + 10'd4);
            step(1);
            if (acerto) begin
                seen = 1'b1;
                last_hit_cyc = cyc;
            end
        end
        check("kill_seen", 32'(seen), 32'd1);
        check("kill_idx", 32'(acerto_idx), 32'(i));
        bala_ativa = 1'b0;
    endtask

    initial begin
        int hits;
        bit frozen;
        int px, py;

        // ---------------- reset values and first move ----------------
        do_reset(1'b0);
        check("rst_x0", 32'(ex(0)), 32'd10);
        check("rst_y0", 32'(ey(0)), 32'd20);
        check("rst_vivos", 32'(vivos), 32'h3F);
        check("rst_pontos", 32'(pontos), 32'd0);
        check("rst_acerto", 32'(acerto), 32'd0);
        check("rst_acerto_idx", 32'(acerto_idx), 32'd0);
        check("rst_todos", 32'(todos_mortos), 32'd0);
        check("rst_invadiu", 32'(invadiu), 32'd0);
        check("rst_tiro_ativo", 32'(tiro_ativo), 32'd0);
        check("rst_tiro_x", 32'(tiro_x), 32'd0);
        check("rst_tiro_y", 32'(tiro_y), 32'd0);
        step(7);
        check("pre_move_x0", 32'(ex(0)), 32'd10);
        step(1);
        check("move1_x0", 32'(ex(0)), 32'd14);
        check("move1_x1", 32'(ex(1)), 32'd34);
        check("move1_x3", 32'(ex(3)), 32'd14);
        check("move1_y3", 32'(ey(3)), 32'd32);

        // ---------------- march right, drop, march left ----------------
        for (int k = 2; k <= 8; k++) begin
            step(8);
            check("march_right_x0", 32'(ex(0)), 32'(10 + 4*k));
        end
        step(8);  // 42+56+4 > 100: drop instead of step
        check("drop_y0", 32'(ey(0)), 32'd28);
        check("drop_x0", 32'(ex(0)), 32'd42);
        check("drop_x2", 32'(ex(2)), 32'd82);
        step(8);
        check("left_x0", 32'(ex(0)), 32'd38);
        check("left_y0", 32'(ey(0)), 32'd28);

        // ---------------- single bullet, single kill ----------------
        do_reset(1'b1);
        step(1);  // bullet idle for one edge arms the scanner
        bala_x = 10'd11; bala_y = 10'd21; bala_ativa = 1'b1;
        hits = 0;
        for (int n = 0; n < 30; n++) begin
            step(1);
            if (acerto) hits++;
        end
        bala_ativa = 1'b0;
        check("bullet_hits", 32'(hits), 32'd1);
        check("bullet_idx", 32'(acerto_idx), 32'd0);
        check("bullet_vivos", 32'(vivos), 32'h3E);
        check("bullet_pontos", 32'(pontos), 32'd10);

        // ---------------- pause ----------------
        do_reset(1'b0);
        step(20);
        check("pause_pre_x0", 32'(ex(0)), 32'd18);
        pausa = 1'b1;
        frozen = 1'b1;
        for (int n = 0; n < 100; n++) begin
            step(1);
            if (ex(0) != 10'd18 || ey(0) != 10'd20 || vivos != 6'h3F || acerto !== 1'b0)
                frozen = 1'b0;
        end
        check("pause_frozen", 32'(frozen), 32'd1);
        pausa = 1'b0;
        step(3);
        check("resume_hold_x0", 32'(ex(0)), 32'd18);
        step(1);
        check("resume_step_x0", 32'(ex(0)), 32'd22);

        // ---------------- kill everything ----------------
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) kill(i);
        check("all_vivos", 32'(vivos), 32'd0);
        check("all_pontos", 32'(pontos), 32'd60);
        check("all_todos_same_cycle", 32'(todos_mortos), 32'd0);
        step(1);
        check("all_todos", 32'(todos_mortos), 32'd1);
        check("all_invadiu", 32'(invadiu), 32'd0);
        // Steps taken up to the edge before the wave ended.
        px = 10 + 4 * (last_hit_cyc / 8);
        py = 20;
        step(50);
        check("fim_frozen_x0", 32'(ex(0)), 32'(px));
        check("fim_frozen_y0", 32'(ey(0)), 32'(py));
        check("fim_todos_held", 32'(todos_mortos), 32'd1);

        do_reset(1'b1);
        check("restart_x0", 32'(ex(0)), 32'd10);
        check("restart_y0", 32'(ey(0)), 32'd20);
        check("restart_vivos", 32'(vivos), 32'h3F);
        check("restart_pontos", 32'(pontos), 32'd0);
        check("restart_todos", 32'(todos_mortos), 32'd0);
        check("restart_acerto_idx", 32'(acerto_idx), 32'd0);

`ifdef FORMACAO_TIRO_EN
        // ---------------- enemy shot ----------------
        tiro_consumido = 1'b1;
        kill(1);
        kill(4);
        check("shot_col1_empty", 32'(vivos), 32'h2D);
        for (int s = 0; s < 6; s++) begin
            int col, w;
            bit exp_act;
            logic [9:0] exp_x, exp_y;
            w = 0;
            while (!(m_fc == 3 && m_mc == 1) && w < 20) begin
                step(1);
                w++;
            end
            check("shot_wait", 32'(w < 20), 32'd1);
            tiro_consumido = 1'b0;
            col = int'(m_lfsr % 8'd3);
            exp_act = (col != 1);
            exp_x = 10'(ex(3 + col) + 10'd8);
            exp_y = 10'(ey(3 + col) + 10'd8);
            step(1);
            check("shot_active", 32'(tiro_ativo), 32'(exp_act));
            if (exp_act) begin
                check("shot_x", 32'(tiro_x), 32'(exp_x));
                check("shot_y", 32'(tiro_y), 32'(exp_y));
                step(4);
                check("shot_fall", 32'(tiro_y), 32'(10'(exp_y + 10'd3)));
            end
            tiro_consumido = 1'b1;
            step(1);
            check("shot_consumed", 32'(tiro_ativo), 32'd0);
        end
        tiro_consumido = 1'b0;
`else
        step(20);
        check("noshot_ativo", 32'(tiro_ativo), 32'd0);
        check("noshot_x", 32'(tiro_x), 32'd0);
        check("noshot_y", 32'(tiro_y), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/formacao_inimigos.md
# formacao_inimigos

Parametrised enemy-formation engine for the shooter game: holds a ROWS×COLS grid of enemies, marches it side-to-side and downward on a frame clock, detects player-bullet hits with a sequential scanner, keeps score, and flags end-of-wave or invasion. It sits beside `nave` and `bola` under the top-level entity wrapper, replacing the per-enemy instance array with a single block. Optionally it also fires enemy shots.

## Interface
- `ROWS`, 2, formation rows
- `COLS`, 5, formation columns (N = ROWS*COLS, N ≤ 64)
- `FRAME_DIV`, 833333, clock cycles per frame tick
- `MOVE_FRAMES`, 8, frame ticks per march step
- `STEP`, 4, horizontal step in px
- `DROP`, 8, vertical drop in px at an edge
- `GAP`, 4, px between enemies
- `X_INI` / `Y_INI`, 10 / 40, formation origin after reset
- `X_MAX`, 630, rightmost allowed pixel
- `Y_INVASAO`, 420, invasion line
- `PONTOS_INIMIGO`, 10, score per kill
- `TIRO_VEL`, 3, enemy-shot px per frame
- `CLOCK_50`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `reiniciarJogo`  in  1  synchronous restart; identical effect to `reset`
- `pausa`  in  1  freezes all state except the outputs
- `largura_inimigo`, `altura_inimigo`  in  10  enemy box size
- `bala_x`, `bala_y`  in  10  player bullet position
- `bala_ativa`  in  1  player bullet in flight
- `tiro_consumido`  in  1  enemy shot hit something; clear it
- `x_inimigo`, `y_inimigo`  out  10*N  enemy i at bits [10i+9:10i]
- `vivos`  out  N  alive mask
- `acerto`  out  1  one-cycle hit pulse
- `acerto_idx`  out  6  index of last hit enemy
- `pontos`  out  16  score
- `todos_mortos`, `invadiu`  out  1  end flags
- `tiro_x`, `tiro_y`  out  10; `tiro_ativo`  out  1  enemy shot

## Operation
- Enemy i: row r = i / COLS, col c = i % COLS; x = x_form + c*(largura+GAP), y = y_form + r*(altura+GAP). All sums use 11-bit arithmetic; outputs are truncated to 10 bits.
- Formation width W = COLS*(largura+GAP) − GAP; height H = ROWS*(altura+GAP) − GAP.
- FSM: `DIREITA`, `ESQUERDA`, `FIM`. On a march step in `DIREITA`: if x_form+W+STEP > X_MAX, then y_form += DROP and the state becomes `ESQUERDA`, otherwise x_form += STEP. `ESQUERDA` mirrors this with the condition x_form < STEP and x_form −= STEP.
- `FIM` is entered when `vivos` == 0 (`todos_mortos`=1) or when y_form+H ≥ Y_INVASAO (`invadiu`=1). In `FIM` no marching, no hits, no shots. Only `reset` or `reiniciarJogo` leaves `FIM`.
- Scanner: idx counts 0..N−1, one enemy per cycle, and wraps. The `armado` flag is set while `bala_ativa`=0.
  - A hit occurs when armado & bala_ativa & vivos[idx] & x ≤ bala_x < x+largura & y ≤ bala_y < y+altura.
  - On a hit: vivos[idx] clears, `acerto` pulses, `acerto_idx`=idx, `pontos` += PONTOS_INIMIGO saturating at 16'hFFFF, and `armado` clears. The result is at most one kill per bullet.
- `pausa`=1 holds the frame counter, scanner, FSM, and shot.

## Timing
- Reset values:
  - x_form=X_INI, y_form=Y_INI, state `DIREITA`
  - vivos all 1; pontos=0; acerto=0; acerto_idx=0
  - todos_mortos=0; invadiu=0; tiro_ativo=0; tiro_x=tiro_y=0
  - frame counter=0; move counter=0; idx=0; LFSR=8'hA5
- Frame tick: frame counter reaches FRAME_DIV−1. March step: every MOVE_FRAMES-th frame tick. The first move is visible FRAME_DIV*MOVE_FRAMES cycles after reset deasserts.
- Hit latency: ≤ N cycles from bullet overlap to `acerto`. `vivos`, `pontos`, and `acerto` update on the same edge.
- A hit and a march step in the same cycle: the hit is judged on pre-move coordinates, and both take effect.
- The last kill raises `todos_mortos` one cycle after `acerto`.
- `reset` or `reiniciarJogo` mid-operation restores all reset values on the next edge.

## Configuration
- `FORMACAO_TIRO_EN` defined:
  - Spawning: on a march step with `tiro_ativo`=0, the 8-bit LFSR (x^8+x^6+x^5+x^4+1, steps every frame tick) selects column = LFSR % COLS. The lowest alive enemy in that column fires: tiro_x = x+largura/2, tiro_y = y+altura. An empty column produces no shot.
  - Movement: tiro_y += TIRO_VEL each frame tick.
  - Clearing: the shot clears when tiro_y ≥ 470 or when `tiro_consumido`=1. Consume beats spawn in the same cycle.
- Not defined: `tiro_ativo`, `tiro_x`, and `tiro_y` are tied to 0, and the LFSR is absent.

## Test plan
Bench parameters: ROWS=2, COLS=3, FRAME_DIV=4, MOVE_FRAMES=2, STEP=4, DROP=8, GAP=4, largura=16, altura=8, X_INI=10, Y_INI=20, X_MAX=100.
- Reset, then run 8 cycles → x_form=10, vivos=6'b111111, pontos=0; then x_inimigo[0]=14 and x_inimigo[1]=34.
- Free run → x_form steps 10,14,…,42; at the next step y_form=28, x_form=42, state `ESQUERDA`; then x_form=38.
- bala (11,21) with ativa held for 30 cycles → exactly one `acerto`, acerto_idx=0, vivos=6'b111110, pontos=10.
- `pausa` held for 100 cycles mid-march → all outputs frozen; the march resumes on the correct step count after release.
- Kill all 6 → todos_mortos=1, then positions frozen for 50 cycles; `reiniciarJogo` → full reset values.
- With the macro defined, column 1 emptied, and the LFSR selecting column 1 → no shot. With the LFSR selecting column 0 and the lower row alive → tiro_x = x_inimigo[3]+8, tiro_y = y_inimigo[3]+8. `tiro_consumido` → tiro_ativo=0 next cycle.
